// File: rtl/sbox_sweep_checker_if.sv
// Bus between the sweep checker and the S-box under test plus its control/result signals.
// The checker takes the master side; the environment or S-box wrapper takes the slave side.
interface sbox_sweep_checker_if;
    logic       start;
    logic [5:0] sbox_x;
    logic [5:0] sbox_y;
    logic       busy;
    logic       done;
    logic       is_perm;
    logic [6:0] dup_count;
    logic [5:0] first_dup_x;
    logic       first_dup_valid;
    logic [6:0] fixed_count;

    modport master (
        input  start, sbox_y,
        output sbox_x, busy, done, is_perm, dup_count,
               first_dup_x, first_dup_valid, fixed_count
    );

    modport slave (
        output start, sbox_y,
        input  sbox_x, busy, done, is_perm, dup_count,
               first_dup_x, first_dup_valid, fixed_count
    );
endinterface

// File: rtl/sbox_sweep_checker.sv
// Sweeps a 6-bit S-box over all 64 inputs, checking bijectivity with a seen-bitmap
// and counting duplicates and fixed points. LAT is the S-box pipeline depth in cycles.
module sbox_sweep_checker #(
    parameter int LAT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    sbox_sweep_checker_if.master bus
);
    localparam int WW = (LAT > 0) ? $clog2(LAT + 1) : 1;
    localparam logic [WW-1:0] LAT_W = WW'(LAT);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_next;

    logic [WW-1:0] wcnt;
    logic [63:0]   seen;
    logic [5:0]    sbox_x;
    logic [6:0]    dup_count;
    logic [6:0]    fixed_count;
    logic [5:0]    first_dup_x;
    logic          first_dup_valid;
    logic          busy;
    logic          done;
    logic          sample;
    logic          restart;

    assign sample  = (state == RUN) && (wcnt == LAT_W);
    assign restart = bus.start && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (sample && (sbox_x == 6'd63)) state_next = DONE;
            DONE:    if (bus.start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // The bitmap lookup sees the pre-update contents, so a sample is never its own duplicate.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            wcnt            <= '0;
            seen            <= '0;
            sbox_x          <= '0;
            dup_count       <= '0;
            fixed_count     <= '0;
            first_dup_x     <= '0;
            first_dup_valid <= 1'b0;
        end else if (state == RUN) begin
            if (!sample) begin
                wcnt <= wcnt + 1'b1;
            end else begin
                if (seen[bus.sbox_y]) begin
                    dup_count <= dup_count + 7'd1;
                    if (!first_dup_valid) begin
                        first_dup_x     <= sbox_x;
                        first_dup_valid <= 1'b1;
                    end
                end else begin
                    seen[bus.sbox_y] <= 1'b1;
                end
                if (bus.sbox_y == sbox_x) begin
                    fixed_count <= fixed_count + 7'd1;
                end
                if (sbox_x != 6'd63) begin
                    sbox_x <= sbox_x + 6'd1;
                    wcnt   <= '0;
                end
            end
        end
    end

    assign bus.sbox_x          = sbox_x;
    assign bus.busy            = busy;
    assign bus.done            = done;
    assign bus.is_perm         = done && (dup_count == 7'd0);
    assign bus.dup_count       = dup_count;
    assign bus.first_dup_x     = first_dup_x;
    assign bus.first_dup_valid = first_dup_valid;
    assign bus.fixed_count     = fixed_count;
endmodule

// File: tb/tb_sbox_sweep_checker.sv
// Drives two checkers (LAT=0 combinational stub, LAT=2 two-register stub) from a shared
// S-box table and compares their results with a table-based reference model.
module tb_sbox_sweep_checker;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [5:0] tbl [64];
    logic [5:0] p1, p2;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    sbox_sweep_checker_if if0 ();
    sbox_sweep_checker_if if2 ();

    sbox_sweep_checker #(.LAT(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    sbox_sweep_checker #(.LAT(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    assign if0.start  = start;
    assign if2.start  = start;
    assign if0.sbox_y = tbl[if0.sbox_x];

    // Two-register S-box pipeline so the LAT=2 checker sees f(x) two cycles late.
    always @(posedge clk) begin
        p1 <= tbl[if2.sbox_x];
        p2 <= p1;
    end
    assign if2.sbox_y = p2;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        tests++;
        if (observed != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic logic [5:0] gf_mul(input logic [5:0] a, input logic [5:0] b);
        logic [5:0] r;
        logic [5:0] aa;
        r  = '0;
        aa = a;
        for (int i = 0; i < 6; i++) begin
            if (b[i]) r = r ^ aa;
            aa = aa[5] ? ({aa[4:0], 1'b0} ^ 6'h03) : {aa[4:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [5:0] gf_sbox(input logic [5:0] x);
        logic [5:0] r;
        r = 6'd1;
        for (int i = 0; i < 13; i++) r = gf_mul(r, x);
        return r ^ 6'h2D;
    endfunction

    task automatic setTable(input int mode);
        int j;
        logic [5:0] t;
        for (int i = 0; i < 64; i++) begin
            case (mode)
                0: tbl[i] = 6'(i);
                1: tbl[i] = 6'd0;
                2: tbl[i] = 6'(i & 62);
                3: tbl[i] = 6'(i ^ 1);
                4: tbl[i] = gf_sbox(6'(i));
                5: tbl[i] = 6'($urandom_range(0, 63));
                default: tbl[i] = 6'(i);
            endcase
        end
        if (mode == 6) begin
            for (int i = 63; i > 0; i--) begin
                j      = $urandom_range(0, i);
                t      = tbl[i];
                tbl[i] = tbl[j];
                tbl[j] = t;
            end
        end
    endtask

    task automatic model(output int perm, output int dups, output int fdx,
                         output int fdv, output int fixed);
        bit rep;
        dups  = 0;
        fdx   = 0;
        fdv   = 0;
        fixed = 0;
        for (int x = 0; x < 64; x++) begin
            rep = 0;
            for (int k = 0; k < x; k++) if (tbl[k] == tbl[x]) rep = 1;
            if (rep) begin
                dups++;
                if (fdv == 0) begin
                    fdv = 1;
                    fdx = x;
                end
            end
            if (int'(tbl[x]) == x) fixed++;
        end
        perm = (dups == 0) ? 1 : 0;
    endtask

    task automatic checkResults(input string name);
        int perm, dups, fdx, fdv, fixed;
        model(perm, dups, fdx, fdv, fixed);
        checkOutput({name, " lat0 done"},            int'(if0.done), 1);
        checkOutput({name, " lat0 is_perm"},         int'(if0.is_perm), perm);
        checkOutput({name, " lat0 dup_count"},       int'(if0.dup_count), dups);
        checkOutput({name, " lat0 first_dup_valid"}, int'(if0.first_dup_valid), fdv);
        if (fdv != 0) checkOutput({name, " lat0 first_dup_x"}, int'(if0.first_dup_x), fdx);
        checkOutput({name, " lat0 fixed_count"},     int'(if0.fixed_count), fixed);
        checkOutput({name, " lat2 done"},            int'(if2.done), 1);
        checkOutput({name, " lat2 is_perm"},         int'(if2.is_perm), perm);
        checkOutput({name, " lat2 dup_count"},       int'(if2.dup_count), dups);
        checkOutput({name, " lat2 first_dup_valid"}, int'(if2.first_dup_valid), fdv);
        if (fdv != 0) checkOutput({name, " lat2 first_dup_x"}, int'(if2.first_dup_x), fdx);
        checkOutput({name, " lat2 fixed_count"},     int'(if2.fixed_count), fixed);
    endtask

    task automatic checkIdle(input string name);
        checkOutput({name, " lat0 busy"},            int'(if0.busy), 0);
        checkOutput({name, " lat0 done"},            int'(if0.done), 0);
        checkOutput({name, " lat0 is_perm"},         int'(if0.is_perm), 0);
        checkOutput({name, " lat0 sbox_x"},          int'(if0.sbox_x), 0);
        checkOutput({name, " lat0 dup_count"},       int'(if0.dup_count), 0);
        checkOutput({name, " lat0 first_dup_x"},     int'(if0.first_dup_x), 0);
        checkOutput({name, " lat0 first_dup_valid"}, int'(if0.first_dup_valid), 0);
        checkOutput({name, " lat0 fixed_count"},     int'(if0.fixed_count), 0);
        checkOutput({name, " lat2 busy"},            int'(if2.busy), 0);
        checkOutput({name, " lat2 done"},            int'(if2.done), 0);
        checkOutput({name, " lat2 sbox_x"},          int'(if2.sbox_x), 0);
        checkOutput({name, " lat2 dup_count"},       int'(if2.dup_count), 0);
        checkOutput({name, " lat2 fixed_count"},     int'(if2.fixed_count), 0);
    endtask

    // Pulse start, optionally poke start again at poke_x or assert rst at rst_x,
    // and measure the edges from the start edge until each checker reports done.
    task automatic applyStimulus(input string name, input int poke_x, input int rst_x);
        int c0, c2;
        bit poked;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput({name, " lat0 busy at start"}, int'(if0.busy), 1);
        checkOutput({name, " lat0 done at start"}, int'(if0.done), 0);
        checkOutput({name, " lat2 busy at start"}, int'(if2.busy), 1);
        c0    = -1;
        c2    = -1;
        poked = 0;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (rst_x >= 0 && int'(if0.sbox_x) == rst_x) begin
                rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                checkIdle({name, " mid-run reset"});
                return;
            end
            start = (poke_x >= 0 && !poked && int'(if0.sbox_x) == poke_x);
            if (start) poked = 1;
            @(posedge clk);
            #1;
            if (c0 < 0 && if0.done) c0 = n;
            if (c2 < 0 && if2.done) c2 = n;
            if (n == 32) checkOutput({name, " lat0 busy mid-sweep"}, int'(if0.busy), 1);
            if (c0 >= 0 && c2 >= 0) break;
        end
        start = 1'b0;
        checkOutput({name, " lat0 sweep cycles"}, c0, 64);
        checkOutput({name, " lat2 sweep cycles"}, c2, 192);
    endtask

    initial begin
        setTable(0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkIdle("reset");
        rst = 1'b0;

        setTable(0); applyStimulus("identity", -1, -1); checkResults("identity");
        setTable(1); applyStimulus("zero", -1, -1);     checkResults("zero");
        setTable(2); applyStimulus("halve", -1, -1);    checkResults("halve");
        setTable(3); applyStimulus("xor1", -1, -1);     checkResults("xor1");
        setTable(4); applyStimulus("gf sbox", -1, -1);  checkResults("gf sbox");
        applyStimulus("gf sbox start poke", 20, -1);    checkResults("gf sbox start poke");

        for (int r = 0; r < 3; r++) begin
            setTable(5); applyStimulus("random fn", -1, -1);   checkResults("random fn");
            setTable(6); applyStimulus("random perm", -1, -1); checkResults("random perm");
        end

        setTable(5);
        applyStimulus("reset sweep", -1, 30);
        applyStimulus("after reset", -1, -1);
        checkResults("after reset");

        setTable(1);
        applyStimulus("restart from done", -1, -1);
        checkResults("restart from done");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sbox_sweep_checker.md
Name: sbox_sweep_checker

Overview:
Sequential characterisation stage wrapped around the combinational 6-bit S-box path (isomorphism, power-13, inverse isomorphism, affine add). It drives every input 0..63 into the S-box and consumes each output. It also checks bijectivity with a 64-entry seen-bitmap and counts fixed points. It is the bring-up and self-test front end for each SMS32 S-box variant.

Parameters:
LAT, 0, clock cycles between driving sbox_x and sampling sbox_y (0 = S-box purely combinational; >0 = registered S-box pipeline).

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  begin sweep; honoured in IDLE or DONE only
sbox_x  output  6  value driven into the S-box under test
sbox_y  input  6  S-box output for the sbox_x driven LAT cycles earlier
busy  output  1  high while the sweep is running
done  output  1  level, high in DONE while results are valid
is_perm  output  1  1 when done and no duplicate output was seen
dup_count  output  7  number of samples whose output was already seen (0..63)
first_dup_x  output  6  input value at which the first duplicate occurred
first_dup_valid  output  1  first_dup_x holds a captured value
fixed_count  output  7  number of x with sbox_y == x (0..64)

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (rst=1 at a clock edge, any state, including mid-RUN): state IDLE; all outputs 0; sbox_x=0; seen bitmap cleared; wait counter wcnt=0.
- IDLE, start=1: go to RUN. On the same edge: clear bitmap, dup_count, fixed_count, first_dup_valid and first_dup_x; set sbox_x=0, wcnt=0, done=0.
- DONE, start=1: same restart as IDLE. start=0: stay in DONE, results held.
- RUN ignores start. busy=1 exactly while in RUN.
- RUN, each cycle where wcnt<LAT: wcnt++. sbox_x is held.
- RUN, cycle where wcnt==LAT (sample cycle), evaluated on sbox_y at that edge:
  - seen[sbox_y]=1 already: dup_count++. If first_dup_valid=0, latch first_dup_x=sbox_x and set first_dup_valid=1.
  - seen[sbox_y]=0: set seen[sbox_y]=1.
  - sbox_y==sbox_x: fixed_count++.
  - If sbox_x==63: go to DONE (no wrap to 0). Otherwise sbox_x++ and wcnt=0.
- Sweep length: exactly 64*(LAT+1) cycles in RUN. done rises on the edge after the final sample cycle.
- Counter widths: dup_count and fixed_count never saturate; the 7-bit range covers the maximum (63 and 64).
- is_perm = done & (dup_count==0). It is 0 outside DONE.
- Within one sample cycle, the bitmap lookup uses the pre-update bitmap. A duplicate and a fixed point in the same sample are both counted.
- sbox_x is driven from a register. With LAT=0, sbox_y is sampled in the same cycle sbox_x is presented.

Test Plan:
- Reset, then stub y=x, LAT=0, pulse start: done rises 64 cycles after the start edge; is_perm=1, dup_count=0, fixed_count=64, first_dup_valid=0.
- Stub y=0: is_perm=0, dup_count=63, first_dup_valid=1, first_dup_x=1, fixed_count=1.
- Stub y={x[5:1],1'b0}: dup_count=32, first_dup_x=1, fixed_count=32, is_perm=0.
- Stub y=x^6'h01 with a 2-stage register pipeline, LAT=2: done after 192 RUN cycles; is_perm=1, fixed_count=0.
- Actual S-box instance, LAT=0: is_perm and fixed_count match the golden software table. Then assert start during RUN at x=20: it is ignored and the sweep completes unchanged.
- Assert rst at sbox_x=30 mid-sweep: next cycle IDLE, all outputs 0. A new start then gives results identical to a clean sweep. start while in DONE restarts with the counters cleared.
